// File: rtl/uart_frame_responder.sv
// UART reply-frame transmitter: byte 0 is a frame counter, the remaining bytes come from a writable payload table.
// Define UART_PARITY_EN to add an even-parity bit (8E1); without it the framing is 8N1.
module uart_frame_responder #(
  parameter int CLK_DIV   = 17,
  parameter int FRAME_LEN = 14,
  parameter int AW        = 6
) (
  input  logic          i_clk80,
  input  logic          i_reset,
  input  logic          i_req,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  output logic          o_tx,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_req_drop,
  output logic [7:0]    o_frame_cnt
);

  localparam int            TW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int            DEPTH  = 2 ** AW;
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
  localparam logic [AW-1:0] I_LAST = AW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  logic          r_req_sync;
  logic          r_req_q;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_data;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic          r_req_drop;
  logic [7:0]    r_frame_cnt;

  logic [7:0]    w_table [DEPTH];
  logic          w_req_rise;
  logic          w_bit_end;
  logic [AW-1:0] w_next_idx;

  // Only addresses 1..FRAME_LEN-1 hold storage; the rest read as zero and ignore writes.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_table
      if (gi >= 1 && gi < FRAME_LEN) begin : g_reg
        logic [7:0] r_byte;
        always_ff @(posedge i_clk80 or posedge i_reset) begin
          if (i_reset) begin
            r_byte <= 8'd0;
          end else if (i_wr_en && i_wr_addr == AW'(gi)) begin
            r_byte <= i_wr_data;
          end
        end
        assign w_table[gi] = r_byte;
      end else begin : g_zero
        assign w_table[gi] = 8'd0;
      end
    end
  endgenerate

  always_ff @(posedge i_clk80 or posedge i_reset) begin
    if (i_reset) begin
      r_req_sync <= 1'b0;
      r_req_q    <= 1'b0;
    end else begin
      r_req_sync <= i_req;
      r_req_q    <= r_req_sync;
    end
  end

  assign w_req_rise = r_req_sync & ~r_req_q;
  assign w_bit_end  = (r_timer == T_LAST);
  assign w_next_idx = r_idx + AW'(1);

  always_ff @(posedge i_clk80 or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_bit       <= 3'd0;
      r_idx       <= '0;
      r_data      <= 8'd0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_req_drop  <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_done     <= 1'b0;
      r_req_drop <= 1'b0;
      // The done cycle still counts as busy for request acceptance.
      if (w_req_rise && (r_state != S_IDLE || r_done)) begin
        r_req_drop <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_req_rise && !r_done) begin
            r_data  <= r_frame_cnt;
            r_idx   <= '0;
            r_timer <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_bit   <= 3'd0;
            r_tx    <= r_data[0];
            r_state <= S_DATA;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_tx    <= ^r_data;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_data[r_bit + 3'd1];
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_timer <= '0;
            // Next byte is sampled from the table only now, so late writes still land in this frame.
            if (r_idx != I_LAST) begin
              r_idx   <= w_next_idx;
              r_data  <= w_table[w_next_idx];
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_state     <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx        = r_tx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_req_drop  = r_req_drop;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_uart_frame_responder.sv
// Scoreboard bench for uart_frame_responder: a UART decoder pops expected bytes queued at request time.
module tb_uart_frame_responder;

  localparam int D  = 3;
  localparam int FL = 5;
  localparam int AW = 3;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int BYTE_CYC  = NBITS * D;
  localparam int FRAME_CYC = FL * BYTE_CYC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = 8'd0;
  logic          tx;
  logic          busy;
  logic          done;
  logic          req_drop;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int drop_cnt = 0;

  logic [7:0] exp_q [$];
  logic [7:0] tbl [FL];
  logic [7:0] exp_cnt = 8'd0;

  bit         mon_active = 1'b0;
  int         mon_c = 0;
  int         mon_bidx = 0;
  int         mon_prev = 0;
  int         mon_bitno = 0;
  int         rx_count = 0;
  logic [7:0] mon_byte = 8'd0;
  logic [7:0] mon_exp;

  uart_frame_responder #(.CLK_DIV(D), .FRAME_LEN(FL), .AW(AW)) dut (
    .i_clk80    (clk),
    .i_reset    (rst),
    .i_req      (req),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_tx       (tx),
    .o_busy     (busy),
    .o_done     (done),
    .o_req_drop (req_drop),
    .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART decoder and scoreboard, sampling mid-bit on the falling edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (req_drop === 1'b1) drop_cnt++;
    if (rst) begin
      mon_active = 1'b0;
      mon_bidx   = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_c      = 0;
        if (mon_bidx > 0) begin
          checks++;
          if (cyc - mon_prev !== BYTE_CYC) begin
            failures++;
            $display("FAIL byte_gap: start spacing %0d cycles, expected %0d", cyc - mon_prev, BYTE_CYC);
          end
        end
        mon_prev = cyc;
      end
    end else begin
      mon_c++;
      if (mon_c % D == D / 2) begin
        mon_bitno = mon_c / D;
        if (mon_bitno == 0) begin
          checks++;
          if (tx !== 1'b0) begin
            failures++;
            $display("FAIL start_bit: tx=%b, expected 0", tx);
          end
        end else if (mon_bitno <= 8) begin
          mon_byte[mon_bitno-1] = tx;
`ifdef UART_PARITY_EN
        end else if (mon_bitno == 9) begin
          checks++;
          if (tx !== ^mon_byte) begin
            failures++;
            $display("FAIL parity_bit: got %b for byte 0x%02h, expected %b", tx, mon_byte, ^mon_byte);
          end
`endif
        end else if (mon_bitno == NBITS - 1) begin
          checks++;
          if (tx !== 1'b1) begin
            failures++;
            $display("FAIL stop_bit: tx=%b, expected 1", tx);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_byte: received %0d with nothing expected", mon_byte);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_byte !== mon_exp) begin
              failures++;
              $display("FAIL rx_byte: frame byte %0d got %0d, expected %0d", mon_bidx, mon_byte, mon_exp);
            end else begin
              $display("rx byte %0d = %0d", mon_bidx, mon_byte);
            end
          end
          rx_count++;
          mon_active = 1'b0;
          mon_bidx   = (mon_bidx + 1) % FL;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic write_tbl(input int a, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
    if (a >= 1 && a < FL) tbl[a] = 8'(d);
  endtask

  task automatic push_frame();
    exp_q.push_back(exp_cnt);
    for (int i = 1; i < FL; i++) exp_q.push_back(tbl[i]);
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < FL; i++) tbl[i] = 8'd0;
    exp_cnt = 8'd0;
  endtask

  // Pulses req for one cycle; c is the cycle count at the falling edge where req rose.
  task automatic send_req(output int c);
    @(negedge clk);
    req = 1'b1;
    c   = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    int n;
    dc = -1;
    n  = 0;
    while (dc < 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) dc = cyc;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b, expected 1", tx); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, expected 0", done); end
    if (req_drop !== 1'b0) begin failures++; $display("FAIL reset_req_drop: got %b, expected 0", req_drop); end
    if (frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_frame();
    int c;
    int dc;
    for (int i = 1; i < FL - 1; i++) write_tbl(i, 5 * i);
    write_tbl(FL - 1, 201);
    write_tbl(0, 55);
    write_tbl(FL, 77);
    write_tbl(7, 88);
    push_frame();
    send_req(c);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL latency_early: tx=%b one edge after req, expected 1", tx); end
    tick(1);
    checks += 2;
    if (tx !== 1'b0) begin failures++; $display("FAIL latency: tx=%b two edges after req, expected 0", tx); end
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_start: got %b, expected 1", busy); end
    wait_done(FRAME_CYC + 20, dc);
    checks += 3;
    if (dc !== c + 2 + FRAME_CYC) begin failures++; $display("FAIL frame_time: done at %0d, expected %0d", dc, c + 2 + FRAME_CYC); end
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_end: got %b in done cycle, expected 0", busy); end
    if (frame_cnt !== 8'd1) begin failures++; $display("FAIL frame_cnt_1: got %0d, expected 1", frame_cnt); end
    tick(1);
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse: done=%b one cycle later, expected 0", done); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL single_left: %0d bytes not received, expected 0", exp_q.size()); end
  endtask

  task automatic test_midframe_write();
    int c;
    int dc;
    exp_q.push_back(exp_cnt);
    for (int i = 1; i < FL - 1; i++) exp_q.push_back(tbl[i]);
    exp_q.push_back(8'd188);
    exp_cnt = exp_cnt + 8'd1;
    send_req(c);
    wait_until(c + 2 + 2 * BYTE_CYC + 4);
    write_tbl(FL - 1, 956);
    write_tbl(1, 99);
    wait_done(FRAME_CYC + 20, dc);
    checks++;
    if (dc !== c + 2 + FRAME_CYC) begin failures++; $display("FAIL mid_frame_time: done at %0d, expected %0d", dc, c + 2 + FRAME_CYC); end
    push_frame();
    send_req(c);
    wait_done(FRAME_CYC + 20, dc);
    checks += 3;
    if (dc !== c + 2 + FRAME_CYC) begin failures++; $display("FAIL mid_next_time: done at %0d, expected %0d", dc, c + 2 + FRAME_CYC); end
    if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL mid_frame_cnt: got %0d, expected %0d", frame_cnt, exp_cnt); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL mid_left: %0d bytes not received, expected 0", exp_q.size()); end
  endtask

  task automatic test_req_drop();
    int c;
    int dc;
    int d0;
    d0 = drop_cnt;
    push_frame();
    send_req(c);
    wait_until(c + 2 + BYTE_CYC + 7);
    req = 1'b1;
    tick(3);
    req = 1'b0;
    // Raise req so that its edge is seen in the done cycle.
    wait_until(c + 1 + FRAME_CYC);
    req = 1'b1;
    wait_done(FRAME_CYC + 20, dc);
    req = 1'b0;
    tick(2 * BYTE_CYC);
    checks += 6;
    if (dc !== c + 2 + FRAME_CYC) begin failures++; $display("FAIL drop_frame_time: done at %0d, expected %0d", dc, c + 2 + FRAME_CYC); end
    if (drop_cnt - d0 !== 2) begin failures++; $display("FAIL req_drop_count: %0d pulses, expected 2", drop_cnt - d0); end
    if (busy !== 1'b0) begin failures++; $display("FAIL drop_no_extra: busy=%b, expected 0", busy); end
    if (tx !== 1'b1) begin failures++; $display("FAIL drop_idle_tx: tx=%b, expected 1", tx); end
    if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL drop_frame_cnt: got %0d, expected %0d", frame_cnt, exp_cnt); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL drop_left: %0d bytes not received, expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int c;
    int dc;
    int d0;
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    tick(2);
    rst = 1'b0;
    tick(1);
    write_tbl(2, 8'hA5);
    write_tbl(FL - 1, 8'h3C);
    d0 = drop_cnt;
    push_frame();
    send_req(c);
    for (int f = 0; f < 260; f++) begin
      wait_done(FRAME_CYC + 20, dc);
      checks++;
      if (dc !== c + 2 + FRAME_CYC) begin
        failures++;
        $display("FAIL b2b_frame_time: frame %0d done at %0d, expected %0d", f, dc, c + 2 + FRAME_CYC);
        break;
      end
      if (f < 259) begin
        push_frame();
        send_req(c);
      end
    end
    tick(2);
    checks += 3;
    if (frame_cnt !== 8'd4) begin failures++; $display("FAIL b2b_frame_cnt: got %0d, expected 4", frame_cnt); end
    if (drop_cnt !== d0) begin failures++; $display("FAIL b2b_drops: %0d pulses, expected 0", drop_cnt - d0); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_left: %0d bytes not received, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    int c;
    int dc;
    int d0;
    for (int i = 1; i < FL; i++) write_tbl(i, 8'hC3);
    push_frame();
    send_req(c);
    wait_until(c + 2 + 3 * BYTE_CYC + 6 * D + 1);
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL pre_reset_tx: bit 5 of 0xC3 is %b, expected 0", tx); end
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (tx !== 1'b1) begin failures++; $display("FAIL async_reset_tx: got %b, expected 1", tx); end
    if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy: got %b, expected 0", busy); end
    @(negedge clk);
    checks++;
    if (frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt_clear: got %0d, expected 0", frame_cnt); end
    tick(2);
    rst = 1'b0;
    clear_model();
    tick(BYTE_CYC);
    checks++;
    if (done_cnt !== d0) begin failures++; $display("FAIL reset_no_done: %0d done pulses, expected 0", done_cnt - d0); end
    push_frame();
    send_req(c);
    wait_done(FRAME_CYC + 20, dc);
    checks += 2;
    if (dc !== c + 2 + FRAME_CYC) begin failures++; $display("FAIL post_reset_time: done at %0d, expected %0d", dc, c + 2 + FRAME_CYC); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL post_reset_left: %0d bytes not received, expected 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < FL; i++) tbl[i] = 8'd0;
    tick(3);
    test_reset();
    test_single_frame();
    test_midframe_write();
    test_req_drop();
    test_back_to_back();
    test_reset_midframe();
    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_frame_responder.md
# uart_frame_responder

Parametrised UART frame transmitter that answers a request strobe with a fixed-length reply frame. Byte 0 is an auto-incrementing frame counter; bytes 1..FRAME_LEN-1 come from an internally held, host-writable payload table. Sits on the clk80 domain behind the UART0 pins and serves as the synthesizable replacement for the bench-side reply generator, for loopback and self-test of the Astra receive path.

## Interface
- CLK_DIV, 17: clk80 cycles per UART bit (80.64 MHz / 4.8 Mbaud ≈ 17); legal 2..65535.
- FRAME_LEN, 14: bytes per frame including the counter byte; legal 2..64.
- AW, 6: payload table address width; must satisfy 2^AW ≥ FRAME_LEN.
- clk80  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  frame request, synchronous level; rising edge starts a frame.
- wr_en  in  1  payload table write strobe.
- wr_addr  in  AW  payload byte index, 1..FRAME_LEN-1.
- wr_data  in  8  payload byte.
- tx  out  1  UART line, idle high.
- busy  out  1  high while a frame is in transmission.
- done  out  1  one-cycle pulse at end of frame.
- req_drop  out  1  one-cycle pulse when a request edge is ignored.
- frame_cnt  out  8  value to be sent in byte 0 of the next frame.

## Operation
- Reset values: tx=1, busy=0, done=0, req_drop=0, frame_cnt=0, all table bytes 0, FSM IDLE.
- req registered once internally; rising edge = req_q==0 && req==1.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (next byte: START | last byte: IDLE).
- IDLE: on rising edge load shift register with frame_cnt, byte index=0, enter START, busy=1.
- START: tx=0 for CLK_DIV cycles. DATA: 8 bits LSB first, CLK_DIV cycles each. STOP: tx=1 for CLK_DIV cycles.
- At end of STOP: if index<FRAME_LEN-1, index+1, load table[index+1], go to START (no idle gap). Otherwise go IDLE, busy=0, done=1 for one cycle, frame_cnt+1 (mod 256, 255->0).
- Byte latched into shift register on the cycle it enters START; table writes to a byte not yet latched take effect in the current frame, writes to already-latched bytes affect the next frame only.
- wr_en with wr_addr=0 or wr_addr≥FRAME_LEN: ignored. Writes allowed in any state.
- Rising req edge while busy=1 (including the done cycle): ignored, req_drop=1 for one cycle; no queuing.
- Bit timer: counter 0..CLK_DIV-1, width clog2(CLK_DIV).
- Reset asserted mid-frame: tx=1 and busy=0 immediately (asynchronous), no done pulse, frame_cnt=0, table cleared.

## Timing
- Request latency: tx falls on the 2nd rising clk80 edge after req first sampled high (1 sync register + FSM transition).
- Byte duration: 10·CLK_DIV cycles (11·CLK_DIV with parity).
- Frame duration: FRAME_LEN·10·CLK_DIV cycles; default 2380 cycles.
- done asserts on the cycle after the last stop bit's final cycle, concurrent with busy falling; earliest accepted new request edge is the cycle after done.
- tx is a registered output; no combinational path from any input to tx.

## Configuration
- UART_PARITY_EN defined: PARITY state inserted between DATA and STOP, one CLK_DIV bit of even parity (XOR of the 8 data bits); byte = 11 bit-times.
- Undefined: no parity state; 8N1 framing, byte = 10 bit-times.

## Test plan
- Reset, table bytes 1..12 = 5,10,…,60, byte 13 = 201, byte 14 not written; single req pulse -> UART decoder at 17 cycles/bit reads 0,5,10,…,60,201; done after 2380 cycles; frame_cnt=1.
- Write 956 truncated to 8 bits (188) to addr 13 while byte 3 is in flight -> same frame byte 13 = 188; rewrite addr 1 = 99 during same frame -> appears only in next frame.
- 260 back-to-back frames (req raised the cycle after each done) -> byte 0 runs 0..255, then 0,1,2,3; no idle gaps inside frames.
- req toggled high mid-frame -> req_drop pulses once, frame unchanged, no extra frame follows.
- Reset asserted at bit 5 of byte 7 -> tx=1 and busy=0 without waiting a clock edge, no done; next req sends counter 0 and all-zero payload.
- With UART_PARITY_EN, byte 0x07 -> parity bit 1; byte 0x0F -> parity bit 0; frame length 14·11·17 = 2618 cycles.
